// File: rtl/frame_stack.sv
// frame_stack: call-frame save/restore engine for the 64x16 register file.
// A save snapshots the 16-word frame export and streams it into a LIFO
// memory one word per cycle; a restore streams the newest frame back into
// a staging register, then presents it atomically with a one-cycle strobe.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for saveReq/restoreReq
// S_SAVE  | writing snapshot words 0..15 into the current top slot
// S_LOAD  | reading words 0..15 of the newest slot into the staging reg
// S_APPLY | frameOut valid, restore strobe high, pop commits at exit
module frame_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         saveReq,
    input  logic                         restoreReq,
    input  logic [16*WIDTH-1:0]          frameIn,
    output logic [16*WIDTH-1:0]          frameOut,
    output logic                         restore,
    output logic                         busy,
    output logic                         saveDone,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int FW = 16 * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = SW + 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SAVE  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_APPLY = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic [FW-1:0]    snap_q, snap_d;
    logic [FW-1:0]    stage_q, stage_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             restore_q, restore_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [DEPTH*16];
    logic [WIDTH-1:0] rdata_q;
    logic             mem_we;
    logic [SW-1:0]    wr_slot, rd_slot;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [3:0]       word_idx;
    logic [3:0]       stage_idx;

    // The top free slot is written; the newest full slot (count-1) is read.
    assign wr_slot   = SW'(count_q);
    assign rd_slot   = SW'(count_q - 1'b1);
    assign word_idx  = cnt_q[3:0];
    assign wr_addr   = {wr_slot, word_idx};
    assign rd_addr   = {rd_slot, word_idx};
    // Read data lags the address by one cycle, so it belongs to word cnt-1.
    assign stage_idx = cnt_q[3:0] - 4'd1;

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        snap_d    = snap_q;
        stage_d   = stage_q;
        frame_d   = frame_q;
        restore_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (saveReq) begin
                    if (full_q) begin
                        err_d = 1'b1;
                    end else begin
                        snap_d  = frameIn;
                        cnt_d   = 5'd0;
                        state_d = S_SAVE;
                    end
                end else if (restoreReq) begin
                    if (empty_q) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = 5'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_SAVE: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    count_d = count_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q != 5'd0) begin
                    stage_d[stage_idx*WIDTH +: WIDTH] = rdata_q;
                end
                // Word 15 arrives on the same edge as the publish, so bypass it.
                if (cnt_q == 5'd16) begin
                    frame_d   = {rdata_q, stage_q[FW-WIDTH-1:0]};
                    restore_d = 1'b1;
                    state_d   = S_APPLY;
                end
            end
            default: begin
                count_d = count_q - 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (state_q != S_IDLE && (saveReq || restoreReq)) begin
            err_d = 1'b1;
        end
    end

    // Control and data registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            snap_q    <= '0;
            stage_q   <= '0;
            frame_q   <= '0;
            restore_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            full_q    <= (count_d == CW'(DEPTH));
            empty_q   <= (count_d == '0);
            snap_q    <= snap_d;
            stage_q   <= stage_d;
            frame_q   <= frame_d;
            restore_q <= restore_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // LIFO storage: one write port for saves, registered read for loads.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= snap_q[word_idx*WIDTH +: WIDTH];
        end
        if (state_q == S_LOAD) begin
            rdata_q <= mem[rd_addr];
        end
    end

    assign frameOut = frame_q;
    assign restore  = restore_q;
    assign busy     = (state_q != S_IDLE);
    assign saveDone = done_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign err      = err_q;

endmodule

// File: tb/tb_frame_stack.sv
// tb_frame_stack: directed bench for frame_stack with a transaction-level
// stack model checked every cycle, plus literal expectations per scenario.
module tb_frame_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int FW    = 16 * WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          saveReq = 1'b0;
    logic          restoreReq = 1'b0;
    logic [FW-1:0] frameIn = '0;
    logic [FW-1:0] frameOut;
    logic          restore, busy, saveDone, full, empty, err;
    logic [3:0]    count;

    int n_checks = 0;
    int n_pass   = 0;
    int restore_hits = 0;
    int done_hits    = 0;

    frame_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .saveReq(saveReq), .restoreReq(restoreReq),
        .frameIn(frameIn), .frameOut(frameOut), .restore(restore), .busy(busy),
        .saveDone(saveDone), .count(count), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk_frame(input logic [15:0] base);
        logic [FW-1:0] f;
        for (int k = 0; k < 16; k++) f[16*k +: 16] = base + 16'(k);
        return f;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Behavioural model: a stack of frames plus the operation in progress
    // and how many cycles it still needs.
    logic [FW-1:0] m_stack[$];
    int            m_op = 0;      // 0 idle, 1 save, 2 restore
    int            m_left = 0;
    logic [FW-1:0] m_snap = '0;
    logic [FW-1:0] m_out = '0;
    bit            m_restore = 0, m_done = 0, m_err = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stack.delete();
            m_op = 0; m_left = 0; m_out = '0;
            m_restore = 0; m_done = 0; m_err = 0;
        end else begin
            m_restore = 0; m_done = 0; m_err = 0;
            if (m_op != 0) begin
                if (saveReq || restoreReq) m_err = 1;
                m_left--;
                if (m_op == 1 && m_left == 0) begin
                    m_stack.push_back(m_snap);
                    m_done = 1;
                    m_op = 0;
                end else if (m_op == 2 && m_left == 1) begin
                    m_out = m_stack[$];
                    m_restore = 1;
                end else if (m_op == 2 && m_left == 0) begin
                    void'(m_stack.pop_back());
                    m_op = 0;
                end
            end else if (saveReq) begin
                if (m_stack.size() == DEPTH) m_err = 1;
                else begin m_snap = frameIn; m_op = 1; m_left = 16; end
            end else if (restoreReq) begin
                if (m_stack.size() == 0) m_err = 1;
                else begin m_op = 2; m_left = 18; end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(posedge clk) begin
        #3;
        check("cyc_busy",     FW'(busy),     FW'(m_op != 0));
        check("cyc_restore",  FW'(restore),  FW'(m_restore));
        check("cyc_saveDone", FW'(saveDone), FW'(m_done));
        check("cyc_err",      FW'(err),      FW'(m_err));
        check("cyc_count",    FW'(count),    FW'(m_stack.size()));
        check("cyc_full",     FW'(full),     FW'(m_stack.size() == DEPTH));
        check("cyc_empty",    FW'(empty),    FW'(m_stack.size() == 0));
        check("cyc_frameOut", frameOut,      m_out);
        if (restore) restore_hits++;
        if (saveDone) done_hits++;
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("wait_idle_timeout", FW'(1), FW'(0));
    endtask

    task automatic do_save(input logic [FW-1:0] f);
        frameIn = f; saveReq = 1'b1;
        @(negedge clk);
        saveReq = 1'b0; frameIn = {8{$urandom}};
        wait_idle();
    endtask

    task automatic do_restore();
        restoreReq = 1'b1;
        @(negedge clk);
        restoreReq = 1'b0;
        wait_idle();
    endtask

    initial begin
        int busy_n, lat, rcyc, errs, hits0;
        // 1: reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_count", FW'(count), FW'(0));
        check("rst_empty", FW'(empty), FW'(1));
        check("rst_full", FW'(full), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_restore", FW'(restore), FW'(0));
        check("rst_frameOut", frameOut, FW'(0));
        check("rst_err", FW'(err), FW'(0));

        // 2: single save / restore with latency measurement
        frameIn = mk_frame(16'h1000); saveReq = 1'b1;
        @(negedge clk);
        saveReq = 1'b0; frameIn = {8{$urandom}};
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_n++;
            @(negedge clk);
        end
        check("save_busy_cycles", FW'(busy_n), FW'(16));
        check("save_done_pulse", FW'(saveDone), FW'(1));
        check("save_count", FW'(count), FW'(1));
        restoreReq = 1'b1;
        lat = 0; rcyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            restoreReq = 1'b0;
            if (restore) begin
                if (lat == 0) lat = i;
                rcyc++;
            end
            if (!busy) break;
        end
        check("restore_latency", FW'(lat), FW'(18));
        check("restore_width", FW'(rcyc), FW'(1));
        check("restore_frame", frameOut, mk_frame(16'h1000));
        check("restore_word0", FW'(frameOut[15:0]), FW'(16'h1000));
        check("restore_word15", FW'(frameOut[255:240]), FW'(16'h100F));
        check("restore_count", FW'(count), FW'(0));

        // 3: fill, overflow, LIFO drain
        for (int f = 0; f < 8; f++) do_save(mk_frame(16'hA000 + 16'(16 * f)));
        check("fill_full", FW'(full), FW'(1));
        check("fill_count", FW'(count), FW'(8));
        saveReq = 1'b1;
        @(negedge clk);
        saveReq = 1'b0;
        check("ovf_err", FW'(err), FW'(1));
        check("ovf_busy", FW'(busy), FW'(0));
        @(negedge clk);
        check("ovf_err_cleared", FW'(err), FW'(0));
        check("ovf_count", FW'(count), FW'(8));
        for (int f = 7; f >= 0; f--) begin
            do_restore();
            check("lifo_frame", frameOut, mk_frame(16'hA000 + 16'(16 * f)));
        end
        check("drain_empty", FW'(empty), FW'(1));

        // 4: underflow
        hits0 = restore_hits;
        restoreReq = 1'b1;
        @(negedge clk);
        restoreReq = 1'b0;
        check("udf_err", FW'(err), FW'(1));
        check("udf_busy", FW'(busy), FW'(0));
        repeat (25) @(negedge clk);
        check("udf_no_restore", FW'(restore_hits - hits0), FW'(0));
        check("udf_frameOut", frameOut, mk_frame(16'hA000));

        // 5: held saveReq while busy, then simultaneous requests
        errs = 0;
        frameIn = mk_frame(16'h5500); saveReq = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (err) errs++;
        end
        saveReq = 1'b0;
        wait_idle();
        check("held_err_pulses", FW'(errs), FW'(9));
        check("held_count", FW'(count), FW'(1));
        hits0 = restore_hits;
        frameIn = mk_frame(16'h6600); saveReq = 1'b1; restoreReq = 1'b1;
        @(negedge clk);
        saveReq = 1'b0; restoreReq = 1'b0;
        check("both_busy", FW'(busy), FW'(1));
        check("both_no_err", FW'(err), FW'(0));
        wait_idle();
        check("both_count", FW'(count), FW'(2));
        check("both_no_restore", FW'(restore_hits - hits0), FW'(0));

        // 6: reset in the middle of a save
        frameIn = mk_frame(16'h7700); saveReq = 1'b1;
        @(negedge clk);
        saveReq = 1'b0;
        repeat (7) @(negedge clk);
        hits0 = done_hits;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_count", FW'(count), FW'(0));
        check("midrst_busy", FW'(busy), FW'(0));
        check("midrst_empty", FW'(empty), FW'(1));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", FW'(done_hits - hits0), FW'(0));
        restoreReq = 1'b1;
        @(negedge clk);
        restoreReq = 1'b0;
        check("midrst_udf_err", FW'(err), FW'(1));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
